booth_mac_seq: RTL
==================

# booth_mac_seq

Sequencer and accumulator that sits directly upstream and downstream of the 8x8 radix-4 Booth multiplier. It accepts signed operand pairs over a valid/ready handshake, resets and launches the multiplier, and waits for its done flag. It then captures the 16-bit product, adds it into a saturating 24-bit accumulator, and presents product plus accumulator over a second valid/ready handshake. A watchdog aborts a job if the multiplier never signals completion.

## Interface
- TIMEOUT, 31: maximum WAIT cycles before a job is aborted (5-bit counter).
- ACC_W, 24: accumulator width in bits (signed).
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_mplier  in  8  signed multiplier operand.
- in_mpcand  in  8  signed multiplicand operand.
- acc_clr  in  1  synchronous accumulator and sat clear, sampled every cycle.
- mul_mplier  out  8  operand to multiplier, registered.
- mul_mpcand  out  8  operand to multiplier, registered.
- mul_go  out  1  multiplier start, one-cycle pulse.
- mul_reset  out  1  multiplier synchronous reset, one-cycle pulse.
- mul_over  in  1  multiplier done flag.
- mul_pdt  in  16  multiplier signed product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_pdt  out  16  captured product of the current job.
- out_acc  out  ACC_W  accumulator value including the current job.
- sat  out  1  sticky saturation flag.
- err  out  1  sticky timeout flag; cleared by the next accepted operand pair.

## Operation
- FSM states: IDLE, LOAD, GO, WAIT, ACC, OUT. Reset state is IDLE.
- **IDLE**
  - in_ready=1.
  - On in_valid: latch both operands into mul_mplier/mul_mpcand, clear err, go to LOAD.
- **LOAD**
  - mul_reset=1 for exactly this cycle; go to GO.
- **GO**
  - mul_go=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- **WAIT**
  - mul_go=0. The watchdog counter increments each cycle.
  - mul_over=1: register mul_pdt into out_pdt and go to ACC.
  - Otherwise, if the counter reaches TIMEOUT: set err and go to IDLE with no output and no accumulation.
  - mul_over wins if it is asserted on the timeout cycle.
- **ACC**
  - acc <= sat(acc + sign_extend(out_pdt)); go to OUT.
- **OUT**
  - out_valid=1, with out_pdt and out_acc held stable.
  - On out_ready: go to IDLE.
- Operands on mul_mplier/mul_mpcand stay stable from LOAD until the next accepted pair; they are never changed mid-job.
- Saturation arithmetic:
  - Sum is computed at ACC_W+1 bits.
  - Above 0x7FFFFF clamps to 0x7FFFFF; below 0x800000 clamps to 0x800000.
  - Any clamp sets sat.
- acc_clr:
  - In any cycle other than ACC, it zeroes acc and clears sat.
  - In the ACC cycle, acc <= sign_extend(out_pdt), i.e. clear applies before the add; sat is cleared, then set only if this add clamps (it cannot).
- in_ready is 0 in every state except IDLE. There is no input buffering.

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - mul_go=0, mul_reset=0.
  - mul_mplier=0, mul_mpcand=0.
  - out_valid=0, out_pdt=0, out_acc=0.
  - sat=0, err=0.
- Cycle sequence for an input handshake in cycle T:
  - LOAD at T+1 (mul_reset high).
  - GO at T+2 (mul_go high).
  - WAIT from T+3.
  - If mul_over is first high in cycle W: ACC at W+1, out_valid high from W+2.
- Minimum back-to-back issue, with out_ready tied high: next in_ready is one cycle after the OUT handshake.
- mul_go and mul_reset are single-cycle pulses and never high together.
- A mul_over seen in any state other than WAIT is ignored.
- Asynchronous reset mid-job:
  - All outputs drop to their reset values immediately.
  - The multiplier is re-initialised by the next job's LOAD.
  - No partial result is emitted.

## Test plan
- **Basic job:** in_mplier=3, in_mpcand=5 → exact LOAD/GO/WAIT pulse timing; out_pdt=0x000F, out_acc=0x00000F.
- **Negative operands:** -128×-128 then 7×-2 → out_pdt 0x4000 then 0xFFF2; out_acc 0x004000 then 0x003FF2.
- **Positive saturation:** 512 consecutive jobs of -128×-128 → out_acc 0x7FC000 after job 511; 0x7FFFFF with sat=1 after job 512. Then acc_clr → acc=0, sat=0.
- **Timeout:** mul_over tied 0 → err=1 and in_ready=1 exactly TIMEOUT cycles after WAIT entry; out_valid never rises; acc unchanged. The next accepted pair clears err.
- **Backpressure:** out_ready held 0 for 10 cycles in OUT → out_valid, out_pdt and out_acc stable; in_ready=0 throughout. Release → IDLE next cycle.
- **Reset and clear corner cases:**
  - reset pulsed mid-WAIT → all outputs reset immediately, no out_valid.
  - acc_clr asserted in the ACC cycle with pdt=0x0010 → out_acc=0x000010.

Source files
------------

// File: rtl/booth_mac_seq.sv
// booth_mac_seq: sequences one Booth multiplier job per operand pair and folds each product
// into a saturating accumulator, with a watchdog that aborts a job the multiplier never finishes.
module booth_mac_seq #(
    parameter int TIMEOUT = 31,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_mplier,
    input  logic [7:0]       in_mpcand,
    input  logic             acc_clr,
    output logic [7:0]       mul_mplier,
    output logic [7:0]       mul_mpcand,
    output logic             mul_go,
    output logic             mul_reset,
    input  logic             mul_over,
    input  logic [15:0]      mul_pdt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_pdt,
    output logic [ACC_W-1:0] out_acc,
    output logic             sat,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, LOAD, GO, WAIT, ACC, OUT} state_t;
    state_t state, state_nx;
    logic [4:0]       cnt;
    logic [ACC_W-1:0] acc, base;
    logic [ACC_W:0]   sum;
    logic             clamp, timeout;

    assign timeout = cnt == 5'(TIMEOUT - 1);
    // clear takes effect before the add when both land in the ACC cycle
    assign base    = acc_clr ? '0 : acc;
    assign sum     = {base[ACC_W-1], base} + {{(ACC_W - 15){out_pdt[15]}}, out_pdt};
    assign clamp   = sum[ACC_W] ^ sum[ACC_W-1];
    assign out_acc = acc;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        mul_reset = 1'b0;
        mul_go    = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                state_nx = in_valid ? LOAD : IDLE;
            end
            LOAD: begin
                mul_reset = 1'b1;
                state_nx  = GO;
            end
            GO: begin
                mul_go   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: state_nx = mul_over ? ACC : timeout ? IDLE : WAIT;
            ACC:  state_nx = OUT;
            OUT: begin
                out_valid = 1'b1;
                state_nx  = out_ready ? IDLE : OUT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt        <= '0;
            mul_mplier <= '0;
            mul_mpcand <= '0;
            out_pdt    <= '0;
            acc        <= '0;
            sat        <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                mul_mplier <= in_mplier;
                mul_mpcand <= in_mpcand;
                err        <= 1'b0;
            end
            if (state == GO) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 5'd1;
            if (state == WAIT && mul_over) out_pdt <= mul_pdt;
            if (state == WAIT && !mul_over && timeout) err <= 1'b1;
            if (state == ACC) begin
                acc <= clamp ? (sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}})
                             : sum[ACC_W-1:0];
                sat <= (sat & ~acc_clr) | clamp;
            end else if (acc_clr) begin
                acc <= '0;
                sat <= 1'b0;
            end
        end
endmodule
